// File: rtl/data_mem_responder.sv
// Single-port data memory that answers the core's req/gnt/rvalid data interface.
// Every grant produces exactly one response on the following cycle: read data, a write ack, or an error.
module data_mem_responder #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          GNT_WAIT    = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic [31:0]             data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o
);

  localparam int          IDX_W       = $clog2(DEPTH_WORDS);
  localparam int          LANES       = DATA_WIDTH / 8;
  localparam logic [31:0] SPAN_BYTES  = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_TARGET = 4'(GNT_WAIT);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [3:0]            wait_q;
  logic [31:0]           offset;
  logic                  in_range;
  logic [IDX_W-1:0]      word_idx;
  logic                  handshake;

  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  // Addresses below the base wrap to a huge offset and so fall out of range.
  assign offset    = data_addr_i - BASE_ADDR;
  assign in_range  = offset < SPAN_BYTES;
  assign word_idx  = offset[IDX_W+1:2];

  assign data_gnt_o = data_req_i && (wait_q == WAIT_TARGET) && !rst_i;
  assign handshake  = data_req_i && data_gnt_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || !data_req_i || handshake) begin
      wait_q <= 4'd0;
    end else begin
      wait_q <= wait_q + 4'd1;
    end
  end

  // Memory has no reset so contents survive a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (handshake && data_we_i && in_range) begin
      for (int k = 0; k < LANES; k++) begin
        if (data_be_i[k]) begin
          mem[word_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= handshake;
      rdata_q  <= (handshake && !data_we_i && in_range) ? mem[word_idx] : '0;
      err_q    <= handshake && !in_range;
    end
  end

  // Gating with rst_i cancels a pending response in the very cycle reset is raised.
  assign data_rvalid_o = rvalid_q && !rst_i;
  assign data_rdata_o  = rst_i ? '0 : rdata_q;
  assign data_err_o    = err_q && !rst_i;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: one instance with immediate grant, one with a 3-cycle grant stall.
// A behavioural memory/handshake model predicts every grant and response.
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, we;
  logic [31:0] addr [2];
  logic [3:0]  be [2];
  logic [31:0] wdata [2];

  logic        gnt_a, rvalid_a, err_a;
  logic [31:0] rdata_a;
  logic        gnt_b, rvalid_b, err_b;
  logic [31:0] rdata_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model state, one slot per instance.
  int          wait_cfg [2] = '{0, 3};
  bit          active [2];
  int          start [2];
  bit          pend_v [2];
  bit          pend_e [2];
  bit          pend_known [2];
  logic [31:0] pend_d [2];
  logic [31:0] mdl [int];

  logic [1:0]  last_gnt;
  logic [31:0] last_rdata [2];
  int          rv_seen [2];

  data_mem_responder #(.GNT_WAIT(0)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req[0]), .data_gnt_o(gnt_a),
    .data_addr_i(addr[0]), .data_we_i(we[0]), .data_be_i(be[0]), .data_wdata_i(wdata[0]),
    .data_rvalid_o(rvalid_a), .data_rdata_o(rdata_a), .data_err_o(err_a)
  );

  data_mem_responder #(.GNT_WAIT(3)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req[1]), .data_gnt_o(gnt_b),
    .data_addr_i(addr[1]), .data_we_i(we[1]), .data_be_i(be[1]), .data_wdata_i(wdata[1]),
    .data_rvalid_o(rvalid_b), .data_rdata_o(rdata_b), .data_err_o(err_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drives one cycle on instance d (the other sees req=0), checks both instances
  // at the falling edge, then advances the model with this cycle's predicted handshake.
  task automatic applyStimulus(input int d, input bit r, input bit w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] wd, input bit rs);
    logic        g_gnt, g_rv, g_err, exp_g;
    logic [31:0] g_rd, off, tmp;
    int          key;
    for (int i = 0; i < 2; i++) begin
      req[i] = (i == d) && r;
      we[i] = w; addr[i] = a; be[i] = b; wdata[i] = wd;
    end
    rst = rs;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      g_gnt = (i == 1) ? gnt_b : gnt_a;
      g_rv  = (i == 1) ? rvalid_b : rvalid_a;
      g_err = (i == 1) ? err_b : err_a;
      g_rd  = (i == 1) ? rdata_b : rdata_a;
      if (req[i] && !rs && !active[i]) begin
        active[i] = 1'b1;
        start[i] = cyc;
      end
      exp_g = req[i] && !rs && (cyc - start[i] == wait_cfg[i]);
      checkOutput($sformatf("d%0d_gnt", i), 32'(g_gnt), 32'(exp_g));
      checkOutput($sformatf("d%0d_rvalid", i), 32'(g_rv), 32'(pend_v[i] && !rs));
      if (rs) begin
        checkOutput($sformatf("d%0d_rst_rdata", i), g_rd, 32'h0);
        checkOutput($sformatf("d%0d_rst_err", i), 32'(g_err), 32'h0);
      end else if (pend_v[i]) begin
        checkOutput($sformatf("d%0d_err", i), 32'(g_err), 32'(pend_e[i]));
        if (pend_known[i]) checkOutput($sformatf("d%0d_rdata", i), g_rd, pend_d[i]);
      end
      last_gnt[i] = g_gnt;
      last_rdata[i] = g_rd;
      if (g_rv === 1'b1) rv_seen[i]++;

      pend_v[i] = exp_g; pend_d[i] = 32'h0; pend_e[i] = 1'b0; pend_known[i] = 1'b1;
      if (exp_g) begin
        off = addr[i] - BASE;
        key = i * (1 << 20) + int'(off >> 2);
        if (off >= 32'd4096) begin
          pend_e[i] = 1'b1;
        end else if (we[i]) begin
          if (be[i] == 4'hF) begin
            mdl[key] = wdata[i];
          end else if (mdl.exists(key)) begin
            tmp = mdl[key];
            for (int k = 0; k < 4; k++) if (be[i][k]) tmp[8*k +: 8] = wdata[i][8*k +: 8];
            mdl[key] = tmp;
          end
        end else if (mdl.exists(key)) begin
          pend_d[i] = mdl[key];
        end else begin
          pend_known[i] = 1'b0;
        end
      end
      if (!req[i] || rs || exp_g) active[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int d);
    applyStimulus(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] pickAddr();
    int s;
    s = $urandom_range(0, 9);
    if (s < 8) return BASE + 32'h200 + 32'(s * 4);
    if (s == 8) return BASE - 32'h4 - 32'($urandom_range(0, 3) * 4);
    return BASE + 32'h1000 + 32'($urandom_range(0, 3) * 4);
  endfunction

  initial begin
    int          gnt_at [$];
    int          rv_before;
    bit          hr, hw;
    logic [31:0] ha, hwd;
    logic [3:0]  hb;

    // Reset, including a request presented while reset is high.
    applyStimulus(0, 1'b0, 1'b0, BASE, 4'hF, 32'h0, 1'b1);
    applyStimulus(0, 1'b1, 1'b1, BASE, 4'hF, 32'h1234_5678, 1'b1);
    applyStimulus(1, 1'b1, 1'b1, BASE, 4'hF, 32'h1234_5678, 1'b1);
    idle(0);

    // Word write followed by read on the next cycle.
    applyStimulus(0, 1'b1, 1'b1, 32'h0001_0010, 4'hF, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0001_0010, 4'hF, 32'h0, 1'b0);
    idle(0);
    checkOutput("wr_rd_value", last_rdata[0], 32'hDEAD_BEEF);

    // Byte-enable merge.
    applyStimulus(0, 1'b1, 1'b1, 32'h0001_0020, 4'hF, 32'h1122_3344, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 32'h0001_0020, 4'b0101, 32'hAABB_CCDD, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0001_0020, 4'h0, 32'h0, 1'b0);
    idle(0);
    checkOutput("be_merge", last_rdata[0], 32'h11BB_33DD);

    // Out-of-range below base and past the top must not touch the last word.
    applyStimulus(0, 1'b1, 1'b1, 32'h0001_0FFC, 4'hF, 32'h5A5A_5A5A, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_FFFC, 4'hF, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 32'h0001_1000, 4'hF, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0001_0FFC, 4'hF, 32'h0, 1'b0);
    idle(0);
    checkOutput("oor_last_word", last_rdata[0], 32'h5A5A_5A5A);

    // Write with no byte enables leaves memory as it was.
    applyStimulus(0, 1'b1, 1'b1, 32'h0001_0010, 4'h0, 32'h1234_5678, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0001_0010, 4'hF, 32'h0, 1'b0);
    idle(0);
    checkOutput("be_zero", last_rdata[0], 32'hDEAD_BEEF);

    // Eight back-to-back transactions over four words.
    rv_before = rv_seen[0];
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1'b1, (k % 2) == 0, BASE + 32'h100 + 32'((k / 2) * 4), 4'hF,
                    32'hC0DE_0000 + 32'(k), 1'b0);
    end
    idle(0);
    checkOutput("b2b_pulses", 32'(rv_seen[0] - rv_before), 32'd8);

    // Reset right after a handshake with the next request held across it.
    applyStimulus(0, 1'b1, 1'b0, 32'h0001_0010, 4'hF, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0001_0010, 4'hF, 32'h0, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 32'h0001_0010, 4'hF, 32'h0, 1'b0);
    idle(0);
    checkOutput("rst_mem_kept", last_rdata[0], 32'hDEAD_BEEF);

    // Grant stall on the waiting instance: grants at +3 and +7 of a held request.
    idle(1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 1'b1, 1'b1, 32'h0001_0040, 4'hF, 32'h0BAD_F00D, 1'b0);
      if (last_gnt[1]) gnt_at.push_back(k);
    end
    idle(1);
    checkOutput("stall_gnt_first", 32'(gnt_at.size() > 0 ? gnt_at[0] : -1), 32'd3);
    checkOutput("stall_gnt_second", 32'(gnt_at.size() > 1 ? gnt_at[1] : -1), 32'd7);

    // Reset in the middle of a stalled request, request held through release.
    for (int k = 0; k < 2; k++) applyStimulus(1, 1'b1, 1'b0, 32'h0001_0040, 4'hF, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0001_0040, 4'hF, 32'h0, 1'b1);
    for (int k = 0; k < 5; k++) applyStimulus(1, 1'b1, 1'b0, 32'h0001_0040, 4'hF, 32'h0, 1'b0);
    idle(1);

    // Random traffic on the immediate-grant instance.
    for (int k = 0; k < 8; k++)
      applyStimulus(0, 1'b1, 1'b1, BASE + 32'h200 + 32'(k * 4), 4'hF, $urandom, 1'b0);
    for (int k = 0; k < 150; k++)
      applyStimulus(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pickAddr(),
                    4'($urandom_range(0, 15)), $urandom, 1'b0);
    idle(0);

    // Random traffic on the stalled instance, holding each request until granted.
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++)
        applyStimulus(1, 1'b1, 1'b1, BASE + 32'h200 + 32'(k * 4), 4'hF, 32'h5000_0000 + 32'(k), 1'b0);
    end
    hr = 1'b0; hw = 1'b0; ha = BASE; hb = 4'h0; hwd = 32'h0;
    for (int k = 0; k < 150; k++) begin
      if (!hr || last_gnt[1]) begin
        hr  = $urandom_range(0, 2) != 0;
        hw  = $urandom_range(0, 1) == 1;
        ha  = pickAddr();
        hb  = 4'($urandom_range(0, 15));
        hwd = $urandom;
      end
      applyStimulus(1, hr, hw, ha, hb, hwd, 1'b0);
    end
    idle(1);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
